snn_run_ctrl: RTL and testbench
===============================

Name: snn_run_ctrl

Overview:
- Parametrised timestep sequencer between the AXI config register file and the IF spiking network.
- Latches a run configuration, clears network state, drives rate-coded input spike trains for a programmed number of timesteps and waits for the pipeline to drain.
- Counts output spikes per output neuron and reports completion.
- Replaces the free-running fixed-period spike source with a bounded, repeatable inference run.

Parameters:
- NUM_INPUTS, 4, number of input spike channels
- NUM_OUTPUTS, 2, number of network output neurons
- PERIOD_W, 8, width of each per-channel spike period field
- STEPS_W, 16, width of the timestep count
- COUNT_W, 16, width of each output spike counter
- NET_LATENCY, 2, cycles from a spike_in edge to its earliest effect on spike_out

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- start  in  1  single-cycle run request
- abort  in  1  single-cycle run cancel
- num_steps  in  STEPS_W  RUN-phase length in cycles
- spike_en  in  NUM_INPUTS  per-channel enable
- spike_period  in  NUM_INPUTS*PERIOD_W  per-channel period; channel i uses bits [i*PERIOD_W +: PERIOD_W]
- spike_in  out  NUM_INPUTS  spikes to network
- net_clr  out  1  network state clear pulse
- spike_out  in  NUM_OUTPUTS  spikes from network
- out_count  out  NUM_OUTPUTS*COUNT_W  per-output spike counts
- winner  out  $clog2(NUM_OUTPUTS) (min 1)  index of the largest count
- busy  out  1  run in progress
- done  out  1  run complete, results valid

Behaviour:
- Reset (async, S_AXI_ARESETN=0): state IDLE; all outputs 0; counters, phases and latched config 0.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- busy=1 in CLEAR, RUN and DRAIN. done=1 only in DONE.
- IDLE/DONE + start: go to CLEAR.
- CLEAR (exactly 1 cycle):
  - net_clr=1.
  - Latch num_steps, spike_en and spike_period.
  - Zero all out_count, all phase counters, the step counter and winner.
  - Next state: RUN if latched num_steps!=0, else DRAIN (or DONE if NET_LATENCY=0).
- RUN (exactly num_steps cycles):
  - spike_in[i] = en_q[i] && period_q[i]!=0 && phase[i]==0. Decoded from registers only.
  - Phase update per cycle: phase[i] <= (phase[i]==period_q[i]-1) ? 0 : phase[i]+1. Channel i therefore fires on RUN cycles 0, P, 2P, ...
  - period 0 means the channel is silent. period 1 means it fires every cycle.
- DRAIN: NET_LATENCY cycles with spike_in=0, then DONE. If NET_LATENCY=0, skip DRAIN.
- Counting:
  - In RUN and DRAIN, out_count[j] increments on each cycle spike_out[j]=1.
  - Counters saturate at 2^COUNT_W-1; no wrap.
  - spike_out is ignored in IDLE, CLEAR and DONE.
- DONE:
  - done held high until start (new run, via CLEAR) or abort (to IDLE).
  - out_count is stable throughout.
- start while busy: ignored.
- abort:
  - From any state, next state is IDLE and spike_in is 0 from the next cycle.
  - out_count retains partial values; done is not asserted.
  - abort and start in the same cycle: abort wins.
- Config inputs may change freely during a run; only the values latched in CLEAR are used.
- Reset asserted mid-run: immediate return to the reset values.

Optional Feature:
- Macro SNN_RUN_WINNER_EN.
- Defined: on entry to DONE, winner is registered as the lowest index j with the maximum out_count[j]. It is valid while done=1 and held until the next CLEAR.
- Undefined: no comparator logic is built and winner is tied to 0.

Test Plan:
- Reset with default parameters -> all outputs 0, busy=0, done=0.
- spike_en=4'b1111, periods 1/2/3/0, num_steps=6, start -> net_clr for 1 cycle; spike_in counts over RUN are ch0=6, ch1=3, ch2=2, ch3=0; busy for 1+6+2=9 cycles; then done=1.
- Loopback spike_out[0]=spike_in[0] delayed 2 cycles, spike_out[1] tied low, num_steps=10, period0=1 -> out_count0=10, out_count1=0, winner=0 (macro defined).
- COUNT_W=4, spike_out[1] held high, num_steps=20 -> out_count1 saturates at 15; winner=1.
- abort at RUN cycle 3 of 10 -> IDLE next cycle, spike_in=0, done stays 0, counts keep partial values; a start at RUN cycle 1 is ignored.
- num_steps=0, start -> CLEAR, 2 DRAIN cycles, DONE; no spike_in activity, counts 0.

Source files
------------

// File: rtl/snn_run_ctrl.sv
// -----------------------------------------------------------------------------
// snn_run_ctrl
//
// Timestep sequencer between the AXI config register file and the IF spiking
// network. On start it clears network state and latches a run configuration.
// It then drives rate-coded input spike trains for num_steps cycles and waits
// NET_LATENCY cycles for the network pipeline to drain. While the run is in
// progress it counts output spikes for each output neuron. It reports
// completion with done.
//
// Optional feature (macro SNN_RUN_WINNER_EN):
//   defined   - on entry to DONE, winner holds the lowest index with the
//               largest out_count
//   undefined - no comparator is built and winner is tied to 0
//
// Ports:
//   S_AXI_ACLK     clock
//   S_AXI_ARESETN  asynchronous active-low reset
//   start          single-cycle run request (ignored while busy)
//   abort          single-cycle run cancel (wins over start)
//   num_steps      RUN-phase length in cycles
//   spike_en       per-channel input enable
//   spike_period   per-channel period, channel i at [i*PERIOD_W +: PERIOD_W]
//   spike_in       spikes to the network
//   net_clr        network state clear pulse
//   spike_out      spikes from the network
//   out_count      per-output saturating spike counts
//   winner         index of the largest count
//   busy           run in progress (CLEAR, RUN, DRAIN)
//   done           run complete, results valid
// -----------------------------------------------------------------------------
module snn_run_ctrl #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 2,
    parameter int PERIOD_W    = 8,
    parameter int STEPS_W     = 16,
    parameter int COUNT_W     = 16,
    parameter int NET_LATENCY = 2,
    localparam int WIN_W      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic                            start,
    input  logic                            abort,
    input  logic [STEPS_W-1:0]              num_steps,
    input  logic [NUM_INPUTS-1:0]           spike_en,
    input  logic [NUM_INPUTS*PERIOD_W-1:0]  spike_period,
    output logic [NUM_INPUTS-1:0]           spike_in,
    output logic                            net_clr,
    input  logic [NUM_OUTPUTS-1:0]          spike_out,
    output logic [NUM_OUTPUTS*COUNT_W-1:0]  out_count,
    output logic [WIN_W-1:0]                winner,
    output logic                            busy,
    output logic                            done
);

    localparam int DRAIN_W = (NET_LATENCY > 1) ? $clog2(NET_LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((NET_LATENCY > 0) ? NET_LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                                 r_state;
    state_t                                 w_state_next;

    logic [STEPS_W-1:0]                     r_steps_q;
    logic [NUM_INPUTS-1:0]                  r_en_q;
    logic [NUM_INPUTS-1:0][PERIOD_W-1:0]    r_period_q;
    logic [NUM_INPUTS-1:0][PERIOD_W-1:0]    r_phase;
    logic [NUM_INPUTS-1:0][PERIOD_W-1:0]    w_phase_next;
    logic [STEPS_W-1:0]                     r_step;
    logic [DRAIN_W-1:0]                     r_drain;
    logic [NUM_OUTPUTS-1:0][COUNT_W-1:0]    r_cnt;
    logic [NUM_OUTPUTS-1:0][COUNT_W-1:0]    w_cnt_next;
    logic [NUM_INPUTS-1:0]                  w_spike;
    state_t                                 w_after_run;

    // RUN with zero steps and DRAIN with zero latency are both skipped.
    assign w_after_run = (NET_LATENCY == 0) ? S_DONE : S_DRAIN;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Decided on the value being latched this cycle.
                if (num_steps != '0) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = w_after_run;
                end
            end
            S_RUN: begin
                if (r_step == r_steps_q - STEPS_W'(1)) begin
                    w_state_next = w_after_run;
                end
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (abort) begin
            w_state_next = S_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Phase counters: wrap at period-1 so channel i fires on RUN cycles
    // 0, P, 2P, ...
    // -------------------------------------------------------------------------
    always_comb begin
        w_phase_next = r_phase;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (r_phase[i] == r_period_q[i] - PERIOD_W'(1)) begin
                w_phase_next[i] = '0;
            end else begin
                w_phase_next[i] = r_phase[i] + PERIOD_W'(1);
            end
        end
    end

    // spike_in is decoded from registered state only.
    always_comb begin
        w_spike = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            w_spike[i] = (r_state == S_RUN) && r_en_q[i] &&
                         (r_period_q[i] != '0) && (r_phase[i] == '0);
        end
    end

    // -------------------------------------------------------------------------
    // Output spike counters. The next value is shared with the winner
    // comparator so the final RUN/DRAIN spike is included in the result.
    // -------------------------------------------------------------------------
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_state == S_CLEAR) begin
            w_cnt_next = '0;
        end else if ((r_state == S_RUN) || (r_state == S_DRAIN)) begin
            for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
                if (spike_out[j] && (r_cnt[j] != '1)) begin
                    w_cnt_next[j] = r_cnt[j] + COUNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state    <= S_IDLE;
            r_steps_q  <= '0;
            r_en_q     <= '0;
            r_period_q <= '0;
            r_phase    <= '0;
            r_step     <= '0;
            r_drain    <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            case (r_state)
                S_CLEAR: begin
                    r_steps_q  <= num_steps;
                    r_en_q     <= spike_en;
                    r_period_q <= spike_period;
                    r_phase    <= '0;
                    r_step     <= '0;
                    r_drain    <= '0;
                end
                S_RUN: begin
                    r_phase <= w_phase_next;
                    r_step  <= r_step + STEPS_W'(1);
                end
                S_DRAIN: begin
                    r_drain <= r_drain + DRAIN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SNN_RUN_WINNER_EN
    logic [WIN_W-1:0]   r_winner;
    logic [WIN_W-1:0]   w_win_idx;
    logic [COUNT_W-1:0] w_best;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_best    = w_cnt_next[0];
        w_win_idx = '0;
        for (int unsigned j = 1; j < NUM_OUTPUTS; j++) begin
            if (w_cnt_next[j] > w_best) begin
                w_best    = w_cnt_next[j];
                w_win_idx = WIN_W'(j);
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_winner <= '0;
        end else if (r_state == S_CLEAR) begin
            r_winner <= '0;
            if (w_state_next == S_DONE) begin
                r_winner <= w_win_idx;
            end
        end else if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
            r_winner <= w_win_idx;
        end
    end

    assign winner = r_winner;
`else
    assign winner = '0;
`endif

    assign spike_in  = w_spike;
    assign out_count = r_cnt;
    assign net_clr   = (r_state == S_CLEAR);
    assign busy      = (r_state == S_CLEAR) || (r_state == S_RUN) ||
                       (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_snn_run_ctrl.sv
module tb_snn_run_ctrl;

`ifdef SNN_RUN_WINNER_EN
    localparam bit WIN_ON = 1'b1;
`else
    localparam bit WIN_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] num_steps;
    logic [3:0]  spike_en;
    logic [31:0] spike_period;

    logic [3:0]  spike_in;
    logic        net_clr;
    logic [1:0]  spike_out;
    logic [31:0] out_count;
    logic [0:0]  winner;
    logic        busy;
    logic        done;

    logic [3:0]  s_spike_in;
    logic        s_net_clr;
    logic [1:0]  s_spike_out;
    logic [7:0]  s_out_count;
    logic [0:0]  s_winner;
    logic        s_busy;
    logic        s_done;

    logic [3:0]  d1;
    logic [3:0]  d2;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       busy;
        logic       clr;
        logic       dn;
        logic [3:0] si;
    } exp_t;

    exp_t exp_q[$];
    int   ch_cnt [4];
    int   busy_cycles;
    int   exp_c0;

    snn_run_ctrl u_dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .start         (start),
        .abort         (abort),
        .num_steps     (num_steps),
        .spike_en      (spike_en),
        .spike_period  (spike_period),
        .spike_in      (spike_in),
        .net_clr       (net_clr),
        .spike_out     (spike_out),
        .out_count     (out_count),
        .winner        (winner),
        .busy          (busy),
        .done          (done)
    );

    snn_run_ctrl #(.COUNT_W(4)) u_sat (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .start         (start),
        .abort         (abort),
        .num_steps     (num_steps),
        .spike_en      (spike_en),
        .spike_period  (spike_period),
        .spike_in      (s_spike_in),
        .net_clr       (s_net_clr),
        .spike_out     (s_spike_out),
        .out_count     (s_out_count),
        .winner        (s_winner),
        .busy          (s_busy),
        .done          (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Network stand-in: output 0 is input 0 delayed two cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= '0;
            d2 <= '0;
        end else begin
            d1 <= spike_in;
            d2 <= d1;
        end
    end
    assign spike_out   = {1'b0, d2[0]};
    assign s_spike_out = 2'b10;

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference trace: CLEAR, then up to n_run RUN cycles. Channel i fires on
    // RUN cycle k when enabled, period P != 0 and k is a multiple of P.
    task automatic push_clear_run(input int steps, input logic [3:0] en,
                                  input logic [31:0] per, input int n_run);
        exp_t e;
        logic [7:0] p;
        e = '{busy: 1'b1, clr: 1'b1, dn: 1'b0, si: 4'b0};
        exp_q.push_back(e);
        exp_c0 = 0;
        for (int k = 0; k < steps && k < n_run; k++) begin
            e = '{busy: 1'b1, clr: 1'b0, dn: 1'b0, si: 4'b0};
            for (int i = 0; i < 4; i++) begin
                p = per[i*8 +: 8];
                if (en[i] && p != 0 && (k % int'(p)) == 0) e.si[i] = 1'b1;
            end
            if (e.si[0]) exp_c0++;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_tail;
        exp_t e;
        e = '{busy: 1'b1, clr: 1'b0, dn: 1'b0, si: 4'b0};
        exp_q.push_back(e);
        exp_q.push_back(e);
        e = '{busy: 1'b0, clr: 1'b0, dn: 1'b1, si: 4'b0};
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e = '0;
        for (int k = 0; k < n; k++) exp_q.push_back(e);
    endtask

    // Pops one expected entry per cycle; start_at/abort_at/scramble drive
    // inputs during the cycle with that entry index.
    task automatic drain_trace(input bit scramble, input int start_at, input int abort_at);
        exp_t e;
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++) ch_cnt[i] = 0;
        busy_cycles = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("trace[%0d]", idx), {57'b0, busy, net_clr, done, spike_in},
                  {57'b0, e});
            for (int i = 0; i < 4; i++) ch_cnt[i] += int'(spike_in[i]);
            if (busy) busy_cycles++;
            if (idx == start_at) start = 1'b1;
            if (idx == abort_at) abort = 1'b1;
            if (scramble && idx == 1) begin
                spike_period = $urandom;
                spike_en     = 4'($urandom);
                num_steps    = 16'($urandom_range(1, 50));
            end
            if (exp_q.size() > 0) tick;
            start = 1'b0;
            abort = 1'b0;
            idx++;
        end
    endtask

    task automatic kick;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        num_steps    = '0;
        spike_en     = '0;
        spike_period = '0;

        // Reset state
        #23;
        check("rst_main", {busy, done, net_clr, spike_in, winner, out_count}, 64'd0);
        check("rst_sat", {s_busy, s_done, s_net_clr, s_spike_in, s_winner, s_out_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check("idle_main", {busy, done, net_clr, spike_in, winner, out_count}, 64'd0);

        // Mixed periods 1/2/3/0, config scrambled after CLEAR latches it
        num_steps    = 16'd6;
        spike_en     = 4'b1111;
        spike_period = {8'd0, 8'd3, 8'd2, 8'd1};
        push_clear_run(6, 4'b1111, {8'd0, 8'd3, 8'd2, 8'd1}, 6);
        push_tail();
        kick;
        drain_trace(1'b1, -1, -1);
        check("ch0_spikes", 64'(ch_cnt[0]), 64'd6);
        check("ch1_spikes", 64'(ch_cnt[1]), 64'd3);
        check("ch2_spikes", 64'(ch_cnt[2]), 64'd2);
        check("ch3_spikes", 64'(ch_cnt[3]), 64'd0);
        check("busy_cycles", 64'(busy_cycles), 64'd9);
        check("cnt_a", 64'(out_count), {32'd0, 16'd0, 16'(exp_c0)});
        tick;
        tick;
        check("done_hold", {62'd0, done, busy}, 64'd2);
        check("cnt_a_stable", 64'(out_count), {32'd0, 16'd0, 16'd6});

        // Loopback run, 10 steps, restarted straight from DONE
        num_steps    = 16'd10;
        spike_en     = 4'b0001;
        spike_period = {8'd0, 8'd0, 8'd0, 8'd1};
        push_clear_run(10, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd1}, 10);
        push_tail();
        kick;
        drain_trace(1'b0, -1, -1);
        check("cnt_b", 64'(out_count), {32'd0, 16'd0, 16'd10});
        check("win_b", 64'(winner), 64'd0);

        // start and abort together in DONE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        check("abort_wins", {61'd0, busy, done, net_clr}, 64'd0);
        check("cnt_b_kept", 64'(out_count), {32'd0, 16'd0, 16'd10});

        // 20 steps: sat instance output 1 held high for 22 cycles clamps at 15
        num_steps = 16'd20;
        push_clear_run(20, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd1}, 20);
        push_tail();
        kick;
        drain_trace(1'b0, -1, -1);
        check("cnt_c", 64'(out_count), {32'd0, 16'd0, 16'd20});
        check("sat_cnt", 64'(s_out_count), {56'd0, 4'd15, 4'd0});
        check("sat_win", 64'(s_winner), 64'(WIN_ON));
        check("sat_done", 64'(s_done), 64'd1);

        // Abort during RUN cycle 3 of 10; start during RUN cycle 1 is ignored.
        // Loopback spikes from RUN0/RUN1 land in RUN2/RUN3 -> partial count 2.
        num_steps    = 16'd10;
        spike_en     = 4'b1111;
        spike_period = {8'd0, 8'd3, 8'd2, 8'd1};
        push_clear_run(10, 4'b1111, {8'd0, 8'd3, 8'd2, 8'd1}, 4);
        push_idle(2);
        kick;
        drain_trace(1'b0, 2, 4);
        check("cnt_abort", 64'(out_count), {32'd0, 16'd0, 16'd2});
        tick;
        tick;
        check("cnt_abort_idle", 64'(out_count), {32'd0, 16'd0, 16'd2});
        check("abort_no_done", {62'd0, done, busy}, 64'd0);

        // Zero steps: CLEAR, two DRAIN cycles, DONE
        num_steps = 16'd0;
        push_clear_run(0, 4'b1111, {8'd0, 8'd3, 8'd2, 8'd1}, 0);
        push_tail();
        kick;
        drain_trace(1'b0, -1, -1);
        check("zero_spikes", 64'(ch_cnt[0] + ch_cnt[1] + ch_cnt[2] + ch_cnt[3]), 64'd0);
        check("zero_cnt", 64'(out_count), 64'd0);
        check("zero_busy", 64'(busy_cycles), 64'd3);

        // Reset asserted mid-run
        num_steps    = 16'd10;
        spike_en     = 4'b0001;
        spike_period = {8'd0, 8'd0, 8'd0, 8'd1};
        kick;
        for (int k = 0; k < 5; k++) tick;
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst", {busy, done, net_clr, spike_in, winner, out_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check("post_rst_idle", {busy, done, net_clr, spike_in, winner, out_count}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
